// File: rtl/stack_cpu_pkg.sv
// rtl/stack_cpu_pkg.sv - shared opcode, ALU-op and controller-state types for the stack CPU
package stack_cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_POPA    = 4'd3,
    S_POPB    = 4'd4,
    S_EXEC    = 4'd5,
    S_PUSHRES = 4'd6,
    S_MEMRD   = 4'd7,
    S_PUSHMEM = 4'd8,
    S_MEMWR   = 4'd9,
    S_JUMP    = 4'd10
  } ctrl_state_e;

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit stack datapath
module stack_controller
  import stack_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] inst,
  output logic       ld_IR,
  output logic       PCorIR,
  output logic       push,
  output logic       pop,
  output logic       MEMorALU,
  output logic       ldA,
  output logic       ldB,
  output logic       PCup,
  output logic       PCwrite,
  output logic       J,
  output logic       JZ,
  output logic       write_enable,
  output logic [1:0] ALUop,
  output logic       done
);

  ctrl_state_e state, state_next;
  opcode_e     op_q;

  // Opcode is latched as DECODE ends so later strobes depend only on registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_ADD;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= opcode_e'(inst);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode_e'(inst))
          OP_PUSH: state_next = S_MEMRD;
          OP_JMP:  state_next = S_JUMP;
          default: state_next = S_POPA;
        endcase
      end
      S_POPA: begin
        case (op_q)
          OP_NOT:  state_next = S_EXEC;
          OP_POP:  state_next = S_MEMWR;
          OP_JZ:   state_next = S_JUMP;
          default: state_next = S_POPB;
        endcase
      end
      S_POPB:   state_next = S_EXEC;
      S_EXEC:   state_next = S_PUSHRES;
      S_MEMRD:  state_next = S_PUSHMEM;
      S_PUSHRES, S_PUSHMEM, S_MEMWR, S_JUMP:
                state_next = run ? S_FETCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ld_IR        = 1'b0;
    PCorIR       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    MEMorALU     = 1'b0;
    ldA          = 1'b0;
    ldB          = 1'b0;
    PCup         = 1'b0;
    PCwrite      = 1'b0;
    J            = 1'b0;
    JZ           = 1'b0;
    write_enable = 1'b0;
    ALUop        = ALU_ADD;
    done         = 1'b0;
    case (state)
      S_FETCH: begin
        ld_IR = 1'b1;
        PCup  = 1'b1;
      end
      S_DECODE: PCwrite = 1'b1;
      S_POPA: begin
        pop = 1'b1;
        ldA = 1'b1;
      end
      S_POPB: begin
        pop = 1'b1;
        ldB = 1'b1;
      end
      S_EXEC: ALUop = op_q[1:0];
      S_PUSHRES: begin
        ALUop    = op_q[1:0];
        MEMorALU = 1'b1;
        push     = 1'b1;
        done     = 1'b1;
      end
      S_MEMRD: PCorIR = 1'b1;
      S_PUSHMEM: begin
        push = 1'b1;
        done = 1'b1;
      end
      S_MEMWR: begin
        PCorIR       = 1'b1;
        write_enable = 1'b1;
        done         = 1'b1;
      end
      S_JUMP: begin
        PCwrite = 1'b1;
        J       = (op_q == OP_JMP);
        JZ      = (op_q == OP_JZ);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - randomized and directed checks of stack_controller against a step-table model
module tb_stack_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [2:0] inst = 3'b000;
  logic       ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable, done;
  logic [1:0] ALUop;
  logic [14:0] dut_vec;

  int errors = 0;
  int checks = 0;

  logic        m_busy;
  int          m_k;
  logic [2:0]  m_op;
  logic [14:0] rec [0:7];

  stack_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .inst(inst),
    .ld_IR(ld_IR), .PCorIR(PCorIR), .push(push), .pop(pop), .MEMorALU(MEMorALU),
    .ldA(ldA), .ldB(ldB), .PCup(PCup), .PCwrite(PCwrite), .J(J), .JZ(JZ),
    .write_enable(write_enable), .ALUop(ALUop), .done(done)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ,
                    write_enable, ALUop, done};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One letter per cycle: F fetch, D decode, A popA, B popB, E exec, P push result,
  // R mem read, M push mem, W mem write, J jump.
  function automatic string seq_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: return "FDABEP";
      3'd3:             return "FDAEP";
      3'd4:             return "FDRM";
      3'd5:             return "FDAW";
      3'd6:             return "FDJ";
      default:          return "FDAJ";
    endcase
  endfunction

  function automatic logic [14:0] exp_vec(input logic [2:0] op, input int k);
    string s;
    byte   c;
    logic [14:0] v;
    s = seq_of(op);
    c = s[k];
    v = '0;
    case (c)
      "F": begin v[14] = 1'b1; v[7] = 1'b1; end
      "D": v[6] = 1'b1;
      "A": begin v[11] = 1'b1; v[9] = 1'b1; end
      "B": begin v[11] = 1'b1; v[8] = 1'b1; end
      "E": v[2:1] = op[1:0];
      "P": begin v[12] = 1'b1; v[10] = 1'b1; v[2:1] = op[1:0]; end
      "R": v[13] = 1'b1;
      "M": v[12] = 1'b1;
      "W": begin v[13] = 1'b1; v[3] = 1'b1; end
      "J": begin v[6] = 1'b1; v[5] = (op == 3'd6); v[4] = (op == 3'd7); end
      default: v = '0;
    endcase
    if (k == s.len() - 1) v[0] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_op   <= 3'd0;
    end else if (!m_busy) begin
      if (run) begin
        m_busy <= 1'b1;
        m_k    <= 0;
      end
    end else begin
      if (m_k == 1) m_op <= inst;
      if (m_k >= 2 && m_k == seq_of(m_op).len() - 1) begin
        if (run) m_k <= 0;
        else     m_busy <= 1'b0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle_outputs", dut_vec, m_busy ? exp_vec(m_op, m_k) : 15'h0);
    chk("push_pop_exclusive", push & pop, 0);
    chk("we_vs_stack", write_enable & (push | pop), 0);
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy && n < 12);
    chk({nm, "_idle_reached"}, m_busy, 0);
    chk({nm, "_idle_outputs"}, dut_vec, 0);
  endtask

  task automatic directed(input logic [2:0] op, input int lat, input int k_chk,
                          input logic [14:0] v_chk, input string nm);
    int n;
    int idx;
    @(posedge clk);
    #2;
    run  = 1'b1;
    inst = op;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ld_IR && n < 6);
    chk({nm, "_fetch_seen"}, ld_IR, 1);
    rec[0] = dut_vec;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      rec[i] = dut_vec;
    end
    idx = -1;
    for (int i = 7; i >= 0; i--) if (rec[i][0]) idx = i;
    chk({nm, "_latency"}, idx + 1, lat);
    chk({nm, "_step_vec"}, rec[k_chk], v_chk);
    chk({nm, "_refetch"}, rec[lat][14], 1);
    @(posedge clk);
    #2;
    run = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    int n;
    #12;
    chk("reset_outputs", dut_vec, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_without_run", dut_vec, 0);

    directed(3'd4, 4, 3, 15'h1001, "push");
    chk("push_fetch_vec", rec[0], 15'h4080);
    chk("push_decode_vec", rec[1], 15'h0040);
    chk("push_memrd_vec", rec[2], 15'h2000);
    directed(3'd0, 6, 5, 15'h1401, "add");
    chk("add_popa_vec", rec[2], 15'h0A00);
    chk("add_popb_vec", rec[3], 15'h0900);
    chk("add_exec_vec", rec[4], 15'h0000);
    directed(3'd1, 6, 4, 15'h0002, "sub");
    directed(3'd3, 5, 4, 15'h1407, "not");
    chk("not_exec_vec", rec[3], 15'h0006);
    directed(3'd5, 4, 3, 15'h2009, "pop");
    directed(3'd6, 3, 2, 15'h0061, "jmp");
    directed(3'd7, 4, 3, 15'h0051, "jz");

    // Abort an ADD during POPB with an asynchronous reset.
    @(posedge clk);
    #2;
    run  = 1'b1;
    inst = 3'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ld_IR && n < 6);
    chk("abort_fetch_seen", ld_IR, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_popb", {pop, ldB}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", dut_vec, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_still_idle", dut_vec, 0);
    @(negedge clk);
    chk("abort_restart_fetch", dut_vec, 15'h4080);
    @(posedge clk);
    #2;
    run = 1'b0;
    wait_idle("abort");

    repeat (600) begin
      @(posedge clk);
      #2;
      run  = ($urandom_range(0, 3) != 0);
      inst = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #2;
    run = 1'b0;
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Multi-cycle control FSM for the 8-bit stack-machine datapath. It sequences fetch, PC increment, decode and execute for the 3-bit instruction set by driving every datapath strobe: IR load, address select, stack push/pop, A/B load, ALU op, PC update, jumps and memory write. It sits beside the datapath and reads only the opcode (`IR[7:5]`) back from it.

## Interface
- No parameters; widths are fixed by the instruction set.
- `clk` input 1: system clock; controller state advances on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: enables instruction execution; sampled only in IDLE and in the last state of each instruction.
- `inst` input 3: opcode from the datapath IR.
- `ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable` output 1 each: datapath strobes.
- `ALUop` output 2: 00 ADD, 01 SUB, 10 AND, 11 NOT.
- `done` output 1: one-cycle pulse in the final cycle of each instruction.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr. addr = `IR[4:0]`.
- States and asserted outputs; unlisted outputs are 0:
  - IDLE: none.
  - FETCH: PCorIR=0, ld_IR, PCup.
  - DECODE: PCwrite (PC ← PC+1).
  - POPA: pop, ldA.
  - POPB: pop, ldB.
  - EXEC: ALUop=inst[1:0].
  - PUSHRES: ALUop held, MEMorALU=1, push.
  - MEMRD: PCorIR=1.
  - PUSHMEM: MEMorALU=0, push.
  - MEMWR: PCorIR=1, write_enable.
  - JUMP: PCwrite, plus J for JMP or JZ for JZ.
- Transitions: IDLE → FETCH when run; FETCH → DECODE.
- DECODE branches on inst:
  - 000–010 → POPA → POPB → EXEC → PUSHRES.
  - 011 → POPA → EXEC → PUSHRES.
  - 100 → MEMRD → PUSHMEM.
  - 101 → POPA → MEMWR.
  - 110 → JUMP.
  - 111 → POPA → JUMP. The jump is conditional on the popped A being zero; the datapath evaluates ZERO.
- Last states (PUSHRES, PUSHMEM, MEMWR, JUMP) assert done, then go to FETCH if run, else IDLE.
- Outputs are pure Moore decode of a registered state; glitch-free by construction.
- ALUop defaults to 00 in every state other than EXEC and PUSHRES.
- Dropping `run` mid-instruction has no effect; the instruction completes.

## Timing
- Reset: state = IDLE; every output 0, including ALUop=00 and done=0. Reset acts immediately and asynchronously, and may abort an instruction mid-flight; no partial push or pop follows.
- The datapath registers capture on the falling edge. Every strobe is stable for a full cycle around its capturing falling edge.
- `inst` is loaded at the falling edge inside FETCH. It is consumed at the rising edge ending DECODE.
- Latency, FETCH to done inclusive:
  - ADD/SUB/AND: 6 cycles.
  - NOT: 5 cycles.
  - PUSH: 4 cycles.
  - POP: 4 cycles.
  - JMP: 3 cycles.
  - JZ: 4 cycles.
- Back-to-back: with run=1, FETCH immediately follows the done cycle; there is no idle bubble.
- At most one of push/pop is high in any cycle. write_enable is never high together with push or pop.

## Structure
- Shared package `stack_cpu_pkg` holds:
  - opcode enum `opcode_e`;
  - ALU op constants `ALU_ADD/SUB/AND/NOT`;
  - controller state enum `ctrl_state_e`.
- The datapath reuses the ALU constants.
- One module only: a state register plus a next-state `always_comb` and an output-decode `always_comb`. No sub-module is warranted.

## Test plan
- Reset, then run=1, inst=100:
  - cycle 1 FETCH: ld_IR=1, PCup=1;
  - cycle 2: PCwrite=1;
  - cycle 3: PCorIR=1;
  - cycle 4: push=1, MEMorALU=0, done=1;
  - cycle 5: ld_IR=1 again.
- inst=000: pop+ldA, then pop+ldB, then ALUop=00, then push+MEMorALU=1+ALUop=00+done. The done pulse lands on cycle 6.
- inst=011: one pop only; ALUop=11 for 2 cycles; done on cycle 5.
- inst=101 then 110:
  - POP: pop/ldA, then write_enable with PCorIR=1 (done cycle 4).
  - JMP: J=1 and PCwrite=1 in cycle 3; JZ=0.
- inst=111: POPA, then JUMP with JZ=1, PCwrite=1, J=0, done.
- run=0 at done → IDLE with all outputs 0. Assert rst_n=0 during POPB of an ADD → outputs 0 in the same cycle, no push ever issued, restart from FETCH.
- All scenarios: assertions that push&pop never both high, and write_enable&(push|pop) never high.
